// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: shared encodings, FSM states and APB address map for the AHB-to-APB bridge
package ahb2apb_pkg;
    localparam int NUM_SLV = 3;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ = 2'b11;
    localparam logic HRESP_OKAY = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    localparam logic [2:0] HSIZE_MAX = 3'b010;
    localparam logic [31:0] SLV_SIZE = 32'h0400_0000;
    localparam logic [NUM_SLV-1:0][31:0] SLV_BASE = {32'h8800_0000, 32'h8400_0000, 32'h8000_0000};
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS_W,
        ST_ACCESS_R,
        ST_RDONE,
        ST_ERR1,
        ST_ERR2
    } state_t;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps an AHB address/size to a one-hot APB select, flagging unmapped or oversized transfers
module apb_addr_decode
    import ahb2apb_pkg::*;
(
    input  logic [31:0]        addr,
    input  logic [2:0]         size,
    output logic [NUM_SLV-1:0] sel,
    output logic               decode_err
);
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SLV; i++) sel[i] = addr - SLV_BASE[i] < SLV_SIZE;
        decode_err = sel == '0 || size > HSIZE_MAX;
    end
endmodule

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: single AHB slave turning each accepted transfer into one APB2 access, or a two-cycle ERROR
module ahb2apb_bridge
    import ahb2apb_pkg::*;
(
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [31:0]        HADDR,
    input  logic               HWRITE,
    input  logic [1:0]         HTRANS,
    input  logic [2:0]         HSIZE,
    input  logic [31:0]        HWDATA,
    output logic               HREADY,
    output logic               HRESP,
    output logic [31:0]        HRDATA,
    output logic [31:0]        PADDR,
    output logic [31:0]        PWDATA,
    output logic               PWRITE,
    output logic [NUM_SLV-1:0] PSEL,
    output logic               PENABLE,
    input  logic [31:0]        PRDATA
);
    state_t state, state_n;
    logic [31:0] haddr_q, addr_nxt;
    logic [2:0] hsize_q, size_nxt;
    logic hwrite_q, accept, dec_err;
    logic [NUM_SLV-1:0] sel_q, dec_sel;

    assign HREADY = state inside {ST_IDLE, ST_ACCESS_W, ST_RDONE, ST_ERR2};
    assign HRESP = state inside {ST_ERR1, ST_ERR2} ? HRESP_ERROR : HRESP_OKAY;
    assign PENABLE = state inside {ST_ACCESS_W, ST_ACCESS_R};
    assign PSEL = state inside {ST_SETUP, ST_ACCESS_W, ST_ACCESS_R} ? sel_q : '0;
    assign accept = HREADY && HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ};
    // decode sees the value the address latch is about to hold, so errors are known at the accept edge
    assign addr_nxt = accept ? HADDR : haddr_q;
    assign size_nxt = accept ? HSIZE : hsize_q;

    apb_addr_decode u_dec (
        .addr       (addr_nxt),
        .size       (size_nxt),
        .sel        (dec_sel),
        .decode_err (dec_err)
    );

    always_comb begin
        state_n = ST_IDLE;
        case (state)
            ST_IDLE, ST_ACCESS_W, ST_RDONE, ST_ERR2:
                state_n = !accept ? ST_IDLE : dec_err ? ST_ERR1 : HWRITE ? ST_WDATA : ST_SETUP;
            ST_WDATA:    state_n = ST_SETUP;
            ST_SETUP:    state_n = hwrite_q ? ST_ACCESS_W : ST_ACCESS_R;
            ST_ACCESS_R: state_n = ST_RDONE;
            ST_ERR1:     state_n = ST_ERR2;
            default:     state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
            haddr_q <= '0;
            hsize_q <= '0;
            hwrite_q <= 1'b0;
            sel_q <= '0;
            PADDR <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            HRDATA <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                haddr_q <= HADDR;
                hsize_q <= HSIZE;
                hwrite_q <= HWRITE;
                sel_q <= dec_sel;
            end
            // APB address/direction only move when a real APB access begins its SETUP
            if (state_n == ST_SETUP) begin
                PADDR <= addr_nxt;
                PWRITE <= accept ? HWRITE : hwrite_q;
            end
            if (state == ST_WDATA) PWDATA <= HWDATA;
            if (state == ST_ACCESS_R) HRDATA <= PRDATA;
        end
    end
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: directed AHB stimulus checked every cycle against a transfer-timeline model
module tb_ahb2apb_bridge;
    logic HCLK = 1'b0;
    logic HRESETn, HWRITE, HREADY, HRESP, PWRITE, PENABLE;
    logic [31:0] HADDR, HWDATA, PRDATA, HRDATA, PADDR, PWDATA;
    logic [1:0] HTRANS;
    logic [2:0] HSIZE, PSEL;
    int total = 0;
    int bad = 0;

    // model: phase counts data-phase cycles of the current transfer (0 = none)
    int m_phase = 0;
    int m_len = 3;
    bit m_err = 0;
    bit m_wr = 0;
    bit m_pwrite = 0;
    logic [2:0] m_sel = '0;
    logic [31:0] m_addr = '0, m_paddr = '0, m_pwdata = '0, m_hrdata = '0;

    ahb2apb_bridge dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge HCLK) begin
        bit ready, in_setup, in_access;
        int su;
        ready = m_phase == 0 || m_phase == m_len;
        if (!HRESETn) begin
            m_phase = 0; m_len = 3; m_err = 0; m_wr = 0; m_sel = '0;
            m_paddr = '0; m_pwdata = '0; m_pwrite = 0; m_hrdata = '0;
        end else begin
            if (!m_err && m_wr && m_phase == 1) begin
                m_pwdata = HWDATA; m_paddr = m_addr; m_pwrite = 1;
            end
            if (!m_err && !m_wr && m_phase == 2) m_hrdata = PRDATA;
            if (ready && HTRANS[1]) begin
                m_wr = HWRITE;
                m_addr = HADDR;
                m_err = !(HADDR >= 32'h8000_0000 && HADDR < 32'h8C00_0000 && HSIZE <= 3'd2);
                m_sel = m_err ? 3'b000 : 3'(3'b001 << ((HADDR - 32'h8000_0000) / 32'h0400_0000));
                m_len = m_err ? 2 : 3;
                m_phase = 1;
                if (!m_err && !m_wr) begin
                    m_paddr = HADDR; m_pwrite = 0;
                end
            end else if (m_phase > 0 && m_phase < m_len) m_phase++;
            else m_phase = 0;
        end
        #1;
        su = m_wr ? 2 : 1;
        in_setup = !m_err && m_phase == su;
        in_access = !m_err && m_phase == su + 1;
        chk("HREADY", 32'(HREADY), 32'(m_phase == 0 || m_phase == m_len));
        chk("HRESP", 32'(HRESP), 32'(m_err && m_phase != 0));
        chk("PSEL", 32'(PSEL), 32'((in_setup || in_access) ? m_sel : 3'b000));
        chk("PENABLE", 32'(PENABLE), 32'(in_access));
        chk("PADDR", PADDR, m_paddr);
        chk("PWRITE", 32'(PWRITE), 32'(m_pwrite));
        chk("PWDATA", PWDATA, m_pwdata);
        chk("HRDATA", HRDATA, m_hrdata);
    end

    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
        int n = 0;
        HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = s; HWDATA = d; PRDATA = d;
        @(negedge HCLK);
        HTRANS = 2'b00;
        while (!HREADY && n < 8) begin
            @(negedge HCLK);
            n++;
        end
        chk("xfer_done", 32'(HREADY), 32'd1);
    endtask

    initial begin
        HRESETn = 0; HTRANS = 2'b10; HADDR = 32'h8000_0000; HWRITE = 1; HSIZE = 3'd2;
        HWDATA = '0; PRDATA = '0;
        repeat (2) @(negedge HCLK);
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_psel", 32'(PSEL), 32'd0);
        HRESETn = 1; HTRANS = 2'b00;
        @(negedge HCLK);
        // single write
        HTRANS = 2'b10; HADDR = 32'h8400_0010; HWRITE = 1;
        @(negedge HCLK);
        HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
        chk("w_wait", 32'(HREADY), 32'd0);
        @(negedge HCLK);
        chk("w_psel", 32'(PSEL), 32'd2);
        chk("w_setup_pen", 32'(PENABLE), 32'd0);
        chk("w_paddr", PADDR, 32'h8400_0010);
        chk("w_pwdata", PWDATA, 32'hDEAD_BEEF);
        chk("w_pwrite", 32'(PWRITE), 32'd1);
        @(negedge HCLK);
        chk("w_pen", 32'(PENABLE), 32'd1);
        chk("w_done", 32'(HREADY), 32'd1);
        HWDATA = '0;
        @(negedge HCLK);
        // single read
        HTRANS = 2'b10; HADDR = 32'h8800_0004; HWRITE = 0;
        @(negedge HCLK);
        HTRANS = 2'b00; PRDATA = 32'h1234_5678;
        chk("r_psel", 32'(PSEL), 32'd4);
        @(negedge HCLK);
        chk("r_pen", 32'(PENABLE), 32'd1);
        chk("r_wait", 32'(HREADY), 32'd0);
        @(negedge HCLK);
        PRDATA = 32'hFFFF_0000;
        chk("r_hrdata", HRDATA, 32'h1234_5678);
        chk("r_done", 32'(HREADY), 32'd1);
        @(negedge HCLK);
        chk("r_hold", HRDATA, 32'h1234_5678);
        // back-to-back write then SEQ read on the same peripheral
        HTRANS = 2'b10; HADDR = 32'h8000_0000; HWRITE = 1;
        @(negedge HCLK);
        HTRANS = 2'b00; HWDATA = 32'hA5A5_0001;
        repeat (2) @(negedge HCLK);
        chk("b2b_w_psel", 32'(PSEL), 32'd1);
        HTRANS = 2'b11; HADDR = 32'h8000_0008; HWRITE = 0;
        @(negedge HCLK);
        HTRANS = 2'b00; PRDATA = 32'hCAFE_F00D;
        chk("b2b_r_psel", 32'(PSEL), 32'd1);
        chk("b2b_r_paddr", PADDR, 32'h8000_0008);
        chk("b2b_r_pen", 32'(PENABLE), 32'd0);
        repeat (2) @(negedge HCLK);
        chk("b2b_hrdata", HRDATA, 32'hCAFE_F00D);
        @(negedge HCLK);
        // errors: unmapped address, then oversized transfer straight out of ERR2
        HTRANS = 2'b10; HADDR = 32'h9000_0000; HWRITE = 1;
        @(negedge HCLK);
        HTRANS = 2'b00;
        chk("e1_hresp", 32'(HRESP), 32'd1);
        chk("e1_hready", 32'(HREADY), 32'd0);
        @(negedge HCLK);
        chk("e2_hready", 32'(HREADY), 32'd1);
        HTRANS = 2'b10; HADDR = 32'h8000_0000; HSIZE = 3'b011;
        @(negedge HCLK);
        HTRANS = 2'b00; HSIZE = 3'd2;
        chk("e3_hresp", 32'(HRESP), 32'd1);
        chk("e3_psel", 32'(PSEL), 32'd0);
        repeat (2) @(negedge HCLK);
        chk("e_clear", 32'(HRESP), 32'd0);
        // BUSY is never accepted
        HTRANS = 2'b01;
        repeat (2) @(negedge HCLK);
        HTRANS = 2'b00;
        // map boundaries and sizes, issued back-to-back
        xfer(32'h8BFF_FFFC, 1, 3'd2, 32'h0101_0101);
        xfer(32'h8C00_0000, 0, 3'd2, 32'h0202_0202);
        xfer(32'h7FFF_FFFC, 0, 3'd2, 32'h0303_0303);
        xfer(32'h83FF_FFFF, 0, 3'd0, 32'h0404_0404);
        xfer(32'h8400_0000, 1, 3'd1, 32'h0505_0505);
        xfer(32'h8400_0000, 1, 3'd1, 32'h0606_0606);
        @(negedge HCLK);
        // reset during ACCESS_R
        HTRANS = 2'b10; HADDR = 32'h8000_0004; HWRITE = 0; PRDATA = 32'h55AA_55AA;
        @(negedge HCLK);
        HTRANS = 2'b00;
        @(negedge HCLK);
        HRESETn = 0;
        @(negedge HCLK);
        chk("mr_psel", 32'(PSEL), 32'd0);
        chk("mr_pen", 32'(PENABLE), 32'd0);
        chk("mr_hready", 32'(HREADY), 32'd1);
        chk("mr_hrdata", HRDATA, 32'd0);
        HRESETn = 1;
        repeat (3) @(negedge HCLK);
        chk("mr_hrdata_after", HRDATA, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
